// File: rtl/dma_bank_buf.sv
// rtl/dma_bank_buf.sv - banked transfer buffer, one producer port, per-bank consumer read ports
module dma_bank_buf #(
  parameter int NUM_BANKS  = 8,
  parameter int DATA_W     = 128,
  parameter int BANK_DEPTH = 256,
  parameter int ADDR_W     = 32,
  parameter int BSEL_W     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                WrEn,
  input  logic [ADDR_W-1:0]                   WrAddr,
  input  logic [DATA_W-1:0]                   WrData,
  input  logic                                WrLast,
  output logic                                WrErr,
  output logic [15:0]                         DropCnt,
  output logic [NUM_BANKS-1:0]                BankFull,
  input  logic [NUM_BANKS-1:0]                RdEn,
  input  logic [NUM_BANKS-1:0][ADDR_W-1:0]    RdAddr,
  input  logic [NUM_BANKS-1:0]                RdRelease,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]    RdData,
  output logic [NUM_BANKS-1:0]                RdValid
);

  localparam int IDX_W = $clog2(BANK_DEPTH);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} bank_state_e;

  bank_state_e                       state_q [NUM_BANKS];
  bank_state_e                       state_d [NUM_BANKS];
  logic [DATA_W-1:0]                 mem_q   [NUM_BANKS][BANK_DEPTH];
  logic [NUM_BANKS-1:0][DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [NUM_BANKS-1:0]              rd_valid_q, rd_valid_d;
  logic                              wr_err_q, wr_err_d;
  logic [15:0]                       drop_cnt_q, drop_cnt_d;

  logic [BSEL_W-1:0]                 wr_bsel;
  logic [IDX_W-1:0]                  wr_idx;
  logic [NUM_BANKS-1:0]              wr_sel;
  logic [NUM_BANKS-1:0]              full_vec;
  logic                              wr_accept;
  logic                              wr_reject;
  logic                              unused_addr;

  assign wr_bsel     = WrAddr[IDX_W+BSEL_W-1:IDX_W];
  assign wr_idx      = WrAddr[IDX_W-1:0];
  assign unused_addr = ^{WrAddr, RdAddr};

  // An out-of-range bank select leaves wr_sel empty, which rejects the write.
  always_comb begin
    wr_sel   = '0;
    full_vec = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      wr_sel[i]   = (int'(wr_bsel) == i);
      full_vec[i] = (state_q[i] == FULL);
    end
    wr_accept = WrEn && |(wr_sel & ~full_vec);
    wr_reject = WrEn && !wr_accept;
  end

  always_comb begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        FILL: if (wr_accept && wr_sel[i] && WrLast) state_d[i] = FULL;
        FULL: if (RdRelease[i])                     state_d[i] = FILL;
        default:                                    state_d[i] = FILL;
      endcase
    end
  end

  // Reads only fire on FULL banks; writes only land in FILL banks, so no port collision.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (RdEn[i] && full_vec[i]) begin
        rd_valid_d[i] = 1'b1;
        rd_data_d[i]  = mem_q[i][RdAddr[i][IDX_W-1:0]];
      end
    end
  end

  always_comb begin
    wr_err_d   = wr_reject;
    drop_cnt_d = drop_cnt_q;
    if (wr_reject && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (wr_accept && wr_sel[i]) mem_q[i][wr_idx] <= WrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= FILL;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      wr_err_q   <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= state_d[i];
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_err_q   <= wr_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign BankFull = full_vec;
  assign RdData   = rd_data_q;
  assign RdValid  = rd_valid_q;
  assign WrErr    = wr_err_q;
  assign DropCnt  = drop_cnt_q;

endmodule

// File: doc/dma_bank_buf.md
# dma_bank_buf

Parametrised banked transfer buffer for the PCIe DMA datapath, generalising the fixed eight-bank inbound RAM array. A single producer port writes beats into NUM_BANKS banks selected by address bits, and commits a bank with a last-beat marker. Each bank then has its own consumer read port with one-cycle registered latency and an explicit release handshake. Per-bank ownership flags stop the producer from overwriting a bank that has not been drained; rejected writes are flagged and counted.

## Interface
- NUM_BANKS, 8, number of banks and read ports (2..16)
- DATA_W, 128, beat width in bits
- BANK_DEPTH, 256, beats per bank (power of two); IDX_W = clog2(BANK_DEPTH)
- ADDR_W, 32, address width of all address ports
- BSEL_W, 4, width of the bank-select field; must satisfy 2^BSEL_W >= NUM_BANKS
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- WrEn  in  1  write strobe, one beat per cycle
- WrAddr  in  ADDR_W  write address; [IDX_W-1:0] beat index, [IDX_W+BSEL_W-1:IDX_W] bank, higher bits ignored
- WrData  in  DATA_W  write beat
- WrLast  in  1  qualifies WrEn; the accepted beat commits its bank
- WrErr  out  1  one-cycle pulse: previous-cycle write was rejected
- DropCnt  out  16  saturating count of rejected writes
- BankFull  out  NUM_BANKS  bank i committed and owned by consumer i
- RdEn  in  NUM_BANKS  per-bank read strobe
- RdAddr  in  NUM_BANKS x ADDR_W  per-bank read address; only [IDX_W-1:0] is used
- RdRelease  in  NUM_BANKS  per-bank release; returns bank to the producer
- RdData  out  NUM_BANKS x DATA_W  registered read data
- RdValid  out  NUM_BANKS  RdData[i] updated this cycle

## Operation
- Bank select b = WrAddr[IDX_W+BSEL_W-1:IDX_W]. A write is accepted iff WrEn && b < NUM_BANKS && !BankFull[b]. An accepted write stores WrData at bank b, index WrAddr[IDX_W-1:0].
- Rejected write (b out of range or bank full): memory is unchanged; WrErr pulses; DropCnt increments and saturates at 16'hFFFF.
- Commit: an accepted write with WrLast sets BankFull[b]. WrLast without WrEn is ignored.
- Each bank i has a two-state ownership FSM: FILL (BankFull=0, producer owns it) -> FULL on accepted WrLast write to i; FULL -> FILL on RdRelease[i]. RdRelease in FILL is ignored.
- Read: RdEn[i] && BankFull[i] reads bank i at RdAddr[i][IDX_W-1:0]. RdEn[i] in FILL is ignored: no RdValid, RdData holds.
- RdData[i] holds its last value when no read occurs.
- Read ports are independent; all NUM_BANKS may read in the same cycle. The write port never collides with a read, because reads require FULL and writes require FILL.
- Memory contents are not reset. Reading a committed bank index that was never written returns undefined data; the bench must not check it.

## Timing
- Reset (async assert, sync-safe deassert): BankFull=0, RdValid=0, RdData=0, WrErr=0, DropCnt=0, all FSMs in FILL. Reset mid-transfer discards all ownership; banks must be refilled.
- Write: data is visible to reads issued from the cycle after the accepting edge.
- BankFull[b] rises the cycle after the accepted WrLast beat, so a read of that bank can issue that cycle.
- Read latency is 1: RdEn at cycle N gives RdData/RdValid at cycle N+1. RdValid is a single-cycle pulse per read.
- RdEn and RdRelease in the same cycle: the read completes with valid data at N+1, and BankFull clears at N+1.
- Release and a producer write to the same bank in the same cycle: the write is rejected, because the flag is sampled before the edge. A write in the following cycle is accepted.
- WrErr is high in cycle N+1 for a rejected write at N. DropCnt updates at the same edge.

## Test plan
- Fill and commit: write 256 beats (data = index) to bank 3, last beat with WrLast -> BankFull=8'h08 the next cycle; RdEn[3] at idx 17 -> RdValid[3] one cycle later with RdData[3]=17.
- Overwrite protection: bank 3 FULL, WrEn to bank 3 idx 0 with 'hDEAD -> WrErr pulse, DropCnt=1; read idx 0 returns 0, not 'hDEAD.
- Out-of-range bank: WrAddr bank field 4'hA with NUM_BANKS=8 -> WrErr, DropCnt increments, BankFull unchanged; force DropCnt to 16'hFFFF and reject again -> stays 16'hFFFF.
- Concurrent reads: commit all 8 banks, assert all RdEn with distinct indices -> all 8 RdValid in one cycle with correct data; RdEn[5] to an uncommitted bank -> no RdValid[5].
- Release race: bank 2 FULL; RdRelease[2] and a write to bank 2 in the same cycle -> write rejected, BankFull[2]=0 next cycle; rewrite in the next cycle -> accepted, readback correct after recommit.
- Reset mid-operation: assert rst_n=0 with banks 0 and 4 FULL and a read in flight -> all outputs 0 immediately; after release of reset, writes to banks 0 and 4 are accepted.
